// File: rtl/sram_rr_arb.sv
// sram_rr_arb: work-conserving round-robin arbiter sharing one ZBT SRAM port among four requesters (reqN valid/ready/payload in, respN rdata/valid out, registered zbt issue, tag-tracked read return, sticky err, in-flight read count)
module sram_rr_arb #(
  parameter int RD_LAT  = 6,
  parameter bit PART_EN = 1'b1
) (
  input  logic        clk_sram,
  input  logic        Reset,
  input  logic [17:0] i_req0_adr,
  input  logic        i_req0_we,
  input  logic [31:0] i_req0_wdata,
  input  logic [3:0]  i_req0_be,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [17:0] i_req1_adr,
  input  logic        i_req1_we,
  input  logic [31:0] i_req1_wdata,
  input  logic [3:0]  i_req1_be,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [17:0] i_req2_adr,
  input  logic        i_req2_we,
  input  logic [31:0] i_req2_wdata,
  input  logic [3:0]  i_req2_be,
  input  logic        i_req2_valid,
  output logic        o_req2_ready,
  input  logic [17:0] i_req3_adr,
  input  logic        i_req3_we,
  input  logic [31:0] i_req3_wdata,
  input  logic [3:0]  i_req3_be,
  input  logic        i_req3_valid,
  output logic        o_req3_ready,
  output logic [31:0] o_resp0_rdata,
  output logic        o_resp0_valid,
  output logic [31:0] o_resp1_rdata,
  output logic        o_resp1_valid,
  output logic [31:0] o_resp2_rdata,
  output logic        o_resp2_valid,
  output logic [31:0] o_resp3_rdata,
  output logic        o_resp3_valid,
  output logic [17:0] o_zbt_addr,
  output logic [3:0]  o_zbt_wb,
  output logic [31:0] o_zbt_wdata,
  output logic        o_zbt_wen,
  output logic        o_zbt_ren,
  input  logic [31:0] i_zbt_rdata,
  input  logic        i_zbt_rdata_valid,
  output logic        o_err,
  output logic [3:0]  o_rd_outstanding
);
  logic [3:0]  v, we, rdy;
  logic [17:0] adr [4];
  logic [31:0] wdata [4];
  logic [3:0]  be [4];
  logic [1:0]  ptr_q, ptr_d, gid, zbt_id_q, zbt_id_d;
  logic        gany;
  logic [17:0] addr_q, addr_d;
  logic [3:0]  wb_q, wb_d;
  logic [31:0] wdat_q, wdat_d;
  logic        wen_q, wen_d, ren_q, ren_d;
  logic [RD_LAT-1:0][2:0] tag_q, tag_d;
  logic        tail_v, hit;
  logic [1:0]  tail_id;
  logic [3:0]  rsp_v_q, rsp_v_d;
  logic [31:0] rdata_q [4];
  logic [31:0] rdata_d [4];
  logic        err_q, err_d;
  logic [3:0]  cnt_q, cnt_d;
  assign v     = {i_req3_valid, i_req2_valid, i_req1_valid, i_req0_valid};
  assign we    = {i_req3_we, i_req2_we, i_req1_we, i_req0_we};
  assign adr   = '{i_req0_adr, i_req1_adr, i_req2_adr, i_req3_adr};
  assign wdata = '{i_req0_wdata, i_req1_wdata, i_req2_wdata, i_req3_wdata};
  assign be    = '{i_req0_be, i_req1_be, i_req2_be, i_req3_be};
  // Scan from farthest to nearest so the nearest valid after the pointer wins.
  always_comb begin
    gany = 1'b0;
    gid  = ptr_q;
    for (int i = 4; i >= 1; i--)
      if (v[ptr_q + 2'(i)]) begin
        gany = 1'b1;
        gid  = ptr_q + 2'(i);
      end
  end
  assign rdy = gany ? 4'b1 << gid : 4'b0;
  assign {o_req3_ready, o_req2_ready, o_req1_ready, o_req0_ready} = rdy;
  assign tail_v  = tag_q[RD_LAT-1][2];
  assign tail_id = tag_q[RD_LAT-1][1:0];
  assign hit     = tail_v & i_zbt_rdata_valid;
  always_comb begin
    ptr_d    = gany ? gid : ptr_q;
    addr_d   = PART_EN ? {gid, adr[gid][17:2]} : adr[gid];
    wen_d    = gany & we[gid];
    ren_d    = gany & ~we[gid];
    wb_d     = wen_d ? be[gid] : 4'b0;
    wdat_d   = wen_d ? wdata[gid] : 32'b0;
    zbt_id_d = gid;
    tag_d    = {tag_q[RD_LAT-2:0], {ren_q, zbt_id_q}};
    rsp_v_d  = hit ? 4'b1 << tail_id : 4'b0;
    for (int k = 0; k < 4; k++) rdata_d[k] = rsp_v_d[k] ? i_zbt_rdata : rdata_q[k];
    err_d    = err_q | (tail_v ^ i_zbt_rdata_valid);
    cnt_d    = cnt_q + 4'(ren_q) - 4'(tail_v);
  end
  always_ff @(posedge clk_sram or posedge Reset)
    if (Reset) begin
      ptr_q    <= 2'd3;
      addr_q   <= '0;
      wb_q     <= '0;
      wdat_q   <= '0;
      wen_q    <= 1'b0;
      ren_q    <= 1'b0;
      zbt_id_q <= '0;
      tag_q    <= '0;
      rsp_v_q  <= '0;
      rdata_q  <= '{default: '0};
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      wb_q     <= wb_d;
      wdat_q   <= wdat_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
      zbt_id_q <= zbt_id_d;
      tag_q    <= tag_d;
      rsp_v_q  <= rsp_v_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  assign o_zbt_addr       = addr_q;
  assign o_zbt_wb         = wb_q;
  assign o_zbt_wdata      = wdat_q;
  assign o_zbt_wen        = wen_q;
  assign o_zbt_ren        = ren_q;
  assign o_err            = err_q;
  assign o_rd_outstanding = cnt_q;
  assign {o_resp3_valid, o_resp2_valid, o_resp1_valid, o_resp0_valid} = rsp_v_q;
  assign o_resp0_rdata    = rdata_q[0];
  assign o_resp1_rdata    = rdata_q[1];
  assign o_resp2_rdata    = rdata_q[2];
  assign o_resp3_rdata    = rdata_q[3];
endmodule

// File: tb/tb_sram_rr_arb.sv
// tb_sram_rr_arb: directed self-checking bench for sram_rr_arb with a fixed-latency ZBT return model
module tb_sram_rr_arb;
  localparam int RD_LAT = 6;
  logic        clk_sram = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  vld, we, rdy, rv;
  logic [17:0] adr [4];
  logic [31:0] wd [4];
  logic [3:0]  be [4];
  logic [31:0] rd [4];
  logic [17:0] o_zbt_addr;
  logic [3:0]  o_zbt_wb, o_rd_outstanding;
  logic [31:0] o_zbt_wdata, zrd;
  logic        o_zbt_wen, o_zbt_ren, zrv, o_err;
  logic        drop, fixed;
  logic [RD_LAT-1:0] vpipe;
  logic [17:0] apipe [RD_LAT];
  int          checks = 0, failures = 0;
  int          ord [3] = '{3, 0, 1};
  always #5 clk_sram = ~clk_sram;
  always @(posedge clk_sram or posedge Reset)
    if (Reset) vpipe <= '0;
    else begin
      vpipe    <= {vpipe[RD_LAT-2:0], o_zbt_ren & ~drop};
      apipe[0] <= o_zbt_addr;
      for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
    end
  assign zrv = vpipe[RD_LAT-1];
  assign zrd = fixed ? 32'h12345678 : {14'h0, apipe[RD_LAT-1]};
  sram_rr_arb #(.RD_LAT(RD_LAT), .PART_EN(1'b1)) dut (
    .clk_sram(clk_sram), .Reset(Reset),
    .i_req0_adr(adr[0]), .i_req0_we(we[0]), .i_req0_wdata(wd[0]), .i_req0_be(be[0]), .i_req0_valid(vld[0]), .o_req0_ready(rdy[0]),
    .i_req1_adr(adr[1]), .i_req1_we(we[1]), .i_req1_wdata(wd[1]), .i_req1_be(be[1]), .i_req1_valid(vld[1]), .o_req1_ready(rdy[1]),
    .i_req2_adr(adr[2]), .i_req2_we(we[2]), .i_req2_wdata(wd[2]), .i_req2_be(be[2]), .i_req2_valid(vld[2]), .o_req2_ready(rdy[2]),
    .i_req3_adr(adr[3]), .i_req3_we(we[3]), .i_req3_wdata(wd[3]), .i_req3_be(be[3]), .i_req3_valid(vld[3]), .o_req3_ready(rdy[3]),
    .o_resp0_rdata(rd[0]), .o_resp0_valid(rv[0]),
    .o_resp1_rdata(rd[1]), .o_resp1_valid(rv[1]),
    .o_resp2_rdata(rd[2]), .o_resp2_valid(rv[2]),
    .o_resp3_rdata(rd[3]), .o_resp3_valid(rv[3]),
    .o_zbt_addr(o_zbt_addr), .o_zbt_wb(o_zbt_wb), .o_zbt_wdata(o_zbt_wdata),
    .o_zbt_wen(o_zbt_wen), .o_zbt_ren(o_zbt_ren),
    .i_zbt_rdata(zrd), .i_zbt_rdata_valid(zrv),
    .o_err(o_err), .o_rd_outstanding(o_rd_outstanding)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  initial begin
    vld = '0; we = '0; drop = 1'b0; fixed = 1'b0;
    for (int k = 0; k < 4; k++) begin adr[k] = 18'h4; wd[k] = '0; be[k] = 4'hF; end
    repeat (2) @(negedge clk_sram);
    check("rst_ren", o_zbt_ren, 0);
    check("rst_wen", o_zbt_wen, 0);
    check("rst_addr", o_zbt_addr, 0);
    check("rst_err", o_err, 0);
    check("rst_cnt", o_rd_outstanding, 0);
    check("rst_rv", rv, 0);
    @(posedge clk_sram); #1;
    Reset = 1'b0;
    vld = 4'hF;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk_sram);
      if (c < 4) check("t1_rdy", rdy, 4'b1 << c);
      if (c >= 1 && c <= 4) begin
        check("t1_ren", o_zbt_ren, 1);
        check("t1_wen", o_zbt_wen, 0);
        check("t1_addr", o_zbt_addr, {2'(c-1), 16'h1});
      end
      if (c == 4) check("t1_cnt3", o_rd_outstanding, 3);
      if (c == 5) begin check("t1_idle", o_zbt_ren, 0); check("t1_cnt4", o_rd_outstanding, 4); end
      if (c >= 8 && c <= 11) begin
        check("t1_rsp", rv, 4'b1 << (c-8));
        check("t1_rdata", rd[c-8], {14'h0, 2'(c-8), 16'h1});
      end
      if (c == 7 || c == 12) check("t1_norsp", rv, 0);
      if (c == 11) check("t1_cnt0", o_rd_outstanding, 0);
      @(posedge clk_sram); #1;
      if (c < 4) vld[c] = 1'b0;
    end
    we[2] = 1'b1; wd[2] = 32'hDEADBEEF; be[2] = 4'h5; adr[2] = 18'h0ABCD; vld = 4'b0100;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk_sram);
      if (c < 5) check("t2_rdy", rdy, 4'b0100);
      if (c >= 1 && c <= 5) begin
        check("t2_wen", o_zbt_wen, 1);
        check("t2_ren", o_zbt_ren, 0);
        check("t2_wb", o_zbt_wb, 4'h5);
        check("t2_wdata", o_zbt_wdata, 32'hDEADBEEF);
      end
      if (c == 1) check("t2_addr", o_zbt_addr, 18'h22AF3);
      if (c == 6) check("t2_idle", o_zbt_wen, 0);
      @(posedge clk_sram); #1;
      if (c == 4) vld = '0;
    end
    we[0] = 1'b1; we[3] = 1'b1; vld = 4'b1001;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk_sram);
      check("t3_rdy", rdy, (c % 2 == 0) ? 4'b1000 : 4'b0001);
      if (c == 1) check("t3_addr", o_zbt_addr, 18'h30001);
      @(posedge clk_sram); #1;
    end
    vld = '0;
    repeat (3) @(posedge clk_sram); #1;
    fixed = 1'b1; we[1] = 1'b0; adr[1] = 18'h8; vld = 4'b0011;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk_sram);
      if (c == 0) check("t4_rdy1", rdy, 4'b0010);
      if (c == 1 || c == 2) check("t4_rdy0", rdy, 4'b0001);
      if (c == 1) begin check("t4_ren", o_zbt_ren, 1); check("t4_wen0", o_zbt_wen, 0); end
      if (c == 2) begin check("t4_wen", o_zbt_wen, 1); check("t4_ren0", o_zbt_ren, 0); end
      if (c == 7 || c == 9) check("t4_norsp", rv, 0);
      if (c == 8) begin
        check("t4_rsp", rv, 4'b0010);
        check("t4_rdata1", rd[1], 32'h12345678);
        check("t4_rdata0_hold", rd[0], 32'h1);
      end
      if (c == 10) check("t4_err", o_err, 0);
      @(posedge clk_sram); #1;
      if (c == 0) vld[1] = 1'b0;
      if (c == 2) vld[0] = 1'b0;
    end
    drop = 1'b1; we[2] = 1'b0; vld = 4'b0100;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk_sram);
      if (c == 0) check("t5_rdy", rdy, 4'b0100);
      check("t5_norsp", rv, 0);
      if (c == 7) check("t5_err_pre", o_err, 0);
      if (c == 8) begin check("t5_err", o_err, 1); check("t5_cnt", o_rd_outstanding, 0); end
      if (c == 12) check("t5_err_sticky", o_err, 1);
      @(posedge clk_sram); #1;
      if (c == 0) vld = '0;
    end
    drop = 1'b0; we = '0; vld = 4'b1011;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk_sram);
      if (c < 3) check("t6_rdy", rdy, 4'b1 << ord[c]);
      if (c == 3) check("t6_cnt2", o_rd_outstanding, 2);
      if (c == 4) check("t6_cnt3", o_rd_outstanding, 3);
      @(posedge clk_sram); #1;
      if (c < 3) vld[ord[c]] = 1'b0;
    end
    Reset = 1'b1;
    @(negedge clk_sram);
    check("t6_rst_ren", o_zbt_ren, 0);
    check("t6_rst_cnt", o_rd_outstanding, 0);
    check("t6_rst_err", o_err, 0);
    repeat (2) @(posedge clk_sram); #1;
    Reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_sram);
      check("t6_norsp", rv, 0);
    end
    check("t6_cnt0", o_rd_outstanding, 0);
    check("t6_err0", o_err, 0);
    @(posedge clk_sram); #1;
    vld = 4'hF;
    @(negedge clk_sram);
    check("t6_ptr", rdy, 4'b0001);
    @(posedge clk_sram); #1;
    vld = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_rr_arb.md
Name: sram_rr_arb

Overview:
- Work-conserving round-robin arbiter that shares the single ZBT SRAM controller port among four memory requesters.
- Replaces fixed time-slot sharing: an idle requester's slot is reused by any other pending requester.
- Sits between the four requester interfaces and the ZBT controller.
- Tracks outstanding reads with a fixed-latency tag pipeline and routes each returned read word to its owner.

Parameters:
- RD_LAT, 6, cycles from o_zbt_ren high to the matching i_zbt_rdata_valid pulse; legal range 2..15.
- PART_EN, 1, when 1 the SRAM address is {requester id[1:0], req_adr[17:2]} (one quarter per requester); when 0 it is req_adr[17:0] unmodified.

Ports:
- clk_sram  in  1  SRAM clock.
- Reset  in  1  asynchronous, active-high reset.
- i_reqN_adr  in  18  request address, N=0..3.
- i_reqN_we  in  1  1 = write, 0 = read.
- i_reqN_wdata  in  32  write data.
- i_reqN_be  in  4  byte enables, active-high.
- i_reqN_valid  in  1  request pending.
- o_reqN_ready  out  1  grant; the request is accepted when valid & ready.
- o_respN_rdata  out  32  read data.
- o_respN_valid  out  1  one-cycle pulse per returned read.
- o_zbt_addr  out  18  to ZBT controller.
- o_zbt_wb  out  4  byte enables.
- o_zbt_wdata  out  32  write data.
- o_zbt_wen  out  1  write strobe.
- o_zbt_ren  out  1  read strobe.
- i_zbt_rdata  in  32  read data from ZBT controller.
- i_zbt_rdata_valid  in  1  read data valid.
- o_err  out  1  sticky tag-mismatch error flag.
- o_rd_outstanding  out  4  count of reads currently in flight.

Behaviour:
- Reset (async): all outputs 0; priority pointer = 3, so requester 0 has highest priority after reset; tag pipeline cleared; o_err = 0.
- Arbitration:
  - Each cycle, at most one requester is granted.
  - Search order starts at pointer+1 mod 4 and picks the first requester with valid = 1.
  - o_reqN_ready is combinational from the valid signals and the pointer.
  - At most one ready bit is high; ready is never high without the matching valid.
  - On grant to requester k, the pointer is set to k on the next edge.
  - With no valid requests, the pointer holds.
- Fairness: a continuously valid requester is granted within 4 cycles.
- Requester rule: payload must be held stable while valid is high and ready is low. Dropping valid before grant is allowed; nothing is issued for that requester.
- Issue:
  - A request accepted in cycle T drives o_zbt_* registered in cycle T+1.
  - Write: o_zbt_wen = 1, o_zbt_wb = be, o_zbt_wdata = wdata.
  - Read: o_zbt_ren = 1, o_zbt_wb = 0.
  - o_zbt_wen and o_zbt_ren are never high together; both are 0 in idle cycles.
  - Back-to-back issue is supported, up to 1 operation per cycle with no turnaround bubble.
- Address: with PART_EN = 1, requester k at adr A produces o_zbt_addr = {k[1:0], A[17:2]}.
- Tag pipeline:
  - Shift register RD_LAT deep, each entry {valid, id[1:0]}.
  - An entry is pushed on every cycle o_zbt_ren = 1 and advances every cycle.
  - The entry at the tail is compared with i_zbt_rdata_valid.
- Response:
  - When the tail entry is valid and i_zbt_rdata_valid = 1, o_resp{id}_rdata is loaded with i_zbt_rdata.
  - o_resp{id}_valid pulses in the next cycle (1-cycle response register).
  - Read-to-response latency from acceptance = RD_LAT + 2.
  - Each rdata register holds its last value until the next response to that requester.
- Error:
  - A tail entry that is valid with i_zbt_rdata_valid = 0, or a tail entry that is invalid with i_zbt_rdata_valid = 1, sets o_err.
  - o_err is cleared only by Reset.
  - Valid data with no pending tag is discarded.
- o_rd_outstanding:
  - Increments on ren issue and decrements when an entry leaves the tag tail.
  - Simultaneous issue and retire leave it unchanged.
  - Saturates at RD_LAT by construction.
- Reset mid-operation: in-flight reads are dropped, no response pulses are produced, and the pointer returns to 3.

Test Plan:
- Reset, then all four valid with reads to adr 0x00004 → grants in order 0, 1, 2, 3 on consecutive cycles; o_zbt_addr = 0x00001, 0x10001, 0x20001, 0x30001; o_respN_valid pulses at RD_LAT+2 cycles after each grant, in the same order.
- Only requester 2 valid, writing wdata 0xDEADBEEF, be 0x5, for 5 cycles → ready2 high every cycle; 5 consecutive o_zbt_wen pulses with wb = 0x5; no idle slots.
- Requesters 0 and 3 continuously valid → grants alternate 0, 3, 0, 3; no requester waits more than 1 cycle.
- Requester 1 reads while requester 0 writes interleaved; model returns 0x12345678 at RD_LAT → only o_resp1_valid pulses, with rdata 0x12345678; o_err stays 0.
- Model drops one i_zbt_rdata_valid pulse → o_err rises at the tail cycle and stays 1; no o_resp pulse for that read.
- Assert Reset with 3 reads in flight, deassert after 2 cycles → no response pulses; o_rd_outstanding = 0; next grant goes to requester 0.
